// File: rtl/sprite_pkg.sv
// Shared sprite types and helpers used by sprite_drawer and sprite_frontend.
package sprite_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned SPRITE_W = 16;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned FRAME_W  = 8;

  typedef struct packed {
    logic [9:0] col;
    logic       flip;
    logic [7:0] frame;
    logic [3:0] rowoff;
  } job_t;

  typedef enum logic [1:0] {IDLE, FETCH, TAIL} state_t;

  // Pattern ROM address of pixel x of a sprite row; mirroring reverses x.
  function automatic logic [FRAME_W+7:0] rom_addr_f(input logic [7:0] frame,
                                                    input logic [3:0] row,
                                                    input logic [3:0] x,
                                                    input logic       flip);
    return {frame, row, (flip ? (4'd15 - x) : x)};
  endfunction

endpackage

// File: rtl/sprite_drawer_if.sv
// Job handshake between sprite_frontend (master) and sprite_drawer (slave).
interface sprite_drawer_if #(
  parameter int unsigned FRAME_W = 8
);
  logic               start_row;
  logic               draw_req;
  logic [9:0]         col_base;
  logic               flip;
  logic [FRAME_W-1:0] frame_id;
  logic [3:0]         row_off;
  logic               draw_done;
  logic               req_err;

  modport master (
    output start_row, draw_req, col_base, flip, frame_id, row_off,
    input  draw_done, req_err
  );

  modport slave (
    input  start_row, draw_req, col_base, flip, frame_id, row_off,
    output draw_done, req_err
  );
endinterface

// File: rtl/sprite_drawer.sv
// Fetches one 16-pixel sprite row from the pattern ROM and writes the opaque,
// on-screen pixels into the scanline buffer through a 2-stage pipe.
module sprite_drawer
  import sprite_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  sprite_drawer_if.slave     job,
  output logic [FRAME_W+7:0] rom_addr,
  input  logic [PIX_W-1:0]   rom_data,
  output logic               lb_we,
  output logic [9:0]         lb_addr,
  output logic [PIX_W-1:0]   lb_data
);

  state_t             state_q;
  job_t               job_q;
  logic [3:0]         x_q;
  logic               p0_v_q, p1_v_q;
  logic [3:0]         p0_x_q, p1_x_q;
  logic [FRAME_W+7:0] rom_addr_q;
  logic               lb_we_q;
  logic [9:0]         lb_addr_q;
  logic [PIX_W-1:0]   lb_data_q;
  logic               done_q;
  logic               err_q;
  logic [10:0]        col_d;

  // 11-bit column so sprites hanging off the right edge never wrap to column 0.
  always_comb begin
    col_d = {1'b0, job_q.col} + {7'd0, p1_x_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      job_q      <= '0;
      x_q        <= '0;
      p0_v_q     <= 1'b0;
      p0_x_q     <= '0;
      p1_v_q     <= 1'b0;
      p1_x_q     <= '0;
      rom_addr_q <= '0;
      lb_we_q    <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
      done_q     <= 1'b1;
      err_q      <= 1'b0;
    end else if (job.start_row) begin
      state_q <= IDLE;
      x_q     <= '0;
      p0_v_q  <= 1'b0;
      p1_v_q  <= 1'b0;
      lb_we_q <= 1'b0;
      done_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      p1_v_q  <= p0_v_q;
      p1_x_q  <= p0_x_q;
      lb_we_q <= p1_v_q && (rom_data != '0) && (col_d < 11'(H_ACTIVE));
      if (p1_v_q) begin
        lb_addr_q <= col_d[9:0];
        lb_data_q <= rom_data;
      end
      if (job.draw_req && (state_q != IDLE)) begin
        err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          p0_v_q <= 1'b0;
          if (job.draw_req) begin
            job_q      <= '{col: job.col_base, flip: job.flip,
                            frame: job.frame_id, rowoff: job.row_off};
            rom_addr_q <= rom_addr_f(job.frame_id, job.row_off, 4'd0, job.flip);
            p0_v_q     <= 1'b1;
            p0_x_q     <= 4'd0;
            x_q        <= 4'd1;
            done_q     <= 1'b0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          rom_addr_q <= rom_addr_f(job_q.frame, job_q.rowoff, x_q, job_q.flip);
          p0_v_q     <= 1'b1;
          p0_x_q     <= x_q;
          x_q        <= x_q + 4'd1;
          if (x_q == 4'd15) begin
            state_q <= TAIL;
          end
        end
        TAIL: begin
          p0_v_q <= 1'b0;
          // Ready again on the same edge that registers pixel 15's write.
          if (p1_v_q && (p1_x_q == 4'd15)) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr      = rom_addr_q;
  assign lb_we         = lb_we_q;
  assign lb_addr       = lb_addr_q;
  assign lb_data       = lb_data_q;
  assign job.draw_done = done_q;
  assign job.req_err   = err_q;

endmodule

// File: tb/tb_sprite_drawer.sv
// Randomized self-checking bench for sprite_drawer against a per-pixel model.
module tb_sprite_drawer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [7:0]  lb_data;
  logic [7:0]  rom_mem [0:65535];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          err_model = 1'b0;

  always #5 clk = ~clk;

  sprite_drawer_if #(.FRAME_W(8)) jif ();

  sprite_drawer #(.H_ACTIVE(640), .PIX_W(8), .FRAME_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .job      (jif),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .lb_we    (lb_we),
    .lb_addr  (lb_addr),
    .lb_data  (lb_data)
  );

  // Synchronous pattern ROM: data one clock after the address.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int src_of(input int x, input bit flp);
    return flp ? (15 - x) : x;
  endfunction

  function automatic int pix_of(input int frm, input int row, input int x, input bit flp);
    return int'(rom_mem[frm * 256 + row * 16 + src_of(x, flp)]);
  endfunction

  task automatic drive_fields(input int col, input bit flp, input int frm, input int row);
    jif.col_base = 10'(col);
    jif.flip     = flp;
    jif.frame_id = 8'(frm);
    jif.row_off  = 4'(row);
  endtask

  // Leaves the bench at the negedge inside cycle 0 of the new job.
  task automatic start_only(input int col, input bit flp, input int frm, input int row);
    @(negedge clk);
    drive_fields(col, flp, frm, row);
    jif.draw_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    jif.draw_req = 1'b0;
  endtask

  task automatic run_job(input int col, input bit flp, input int frm, input int row,
                         input int busy_cyc);
    int x, p, colx;
    bit we;
    start_only(col, flp, frm, row);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      jif.draw_req = 1'b0;
      if (busy_cyc >= 0 && c == busy_cyc + 1) err_model = 1'b1;
      check_eq("draw_done", 32'(jif.draw_done), 32'(c >= 17));
      check_eq("req_err", 32'(jif.req_err), 32'(err_model));
      if (c <= 15)
        check_eq("rom_addr", 32'(rom_addr), 32'(frm * 256 + row * 16 + src_of(c, flp)));
      if (c >= 2 && c <= 17) begin
        x    = c - 2;
        p    = pix_of(frm, row, x, flp);
        colx = col + x;
        we   = (p != 0) && (colx < 640);
        check_eq("lb_we", 32'(lb_we), 32'(we));
        check_eq("lb_addr", 32'(lb_addr), 32'(colx % 1024));
        check_eq("lb_data", 32'(lb_data), 32'(p));
      end else begin
        check_eq("lb_we_idle", 32'(lb_we), 32'd0);
      end
      if (c == busy_cyc) begin
        drive_fields($urandom_range(0, 1023), 1'b1, $urandom_range(0, 255), 7);
        jif.draw_req = 1'b1;
      end
    end
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check_eq({tag, "_we"}, 32'(lb_we), 32'd0);
      check_eq({tag, "_done"}, 32'(jif.draw_done), 32'd1);
    end
  endtask

  initial begin
    jif.start_row = 1'b0;
    jif.draw_req  = 1'b0;
    drive_fields(0, 1'b0, 0, 0);
    for (int i = 0; i < 65536; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    for (int s = 0; s < 16; s++) rom_mem[3 * 256 + 2 * 16 + s] = 8'(s + 1);
    for (int s = 0; s < 16; s++) rom_mem[5 * 256 + 1 * 16 + s] = (s == 4 || s == 7) ? 8'd0 : 8'hA5;

    // Reset values
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_done", 32'(jif.draw_done), 32'd1);
    check_eq("rst_err", 32'(jif.req_err), 32'd0);
    check_eq("rst_we", 32'(lb_we), 32'd0);
    check_eq("rst_addr", 32'(lb_addr), 32'd0);
    check_eq("rst_data", 32'(lb_data), 32'd0);
    check_eq("rst_rom", 32'(rom_addr), 32'd0);
    reset = 1'b0;

    // Directed jobs: plain, mirrored, right-edge clip with transparent pixels
    run_job(100, 1'b0, 3, 2, -1);
    run_job(100, 1'b1, 3, 2, -1);
    run_job(630, 1'b0, 5, 1, -1);
    run_job(1020, 1'b0, 3, 2, -1);

    // Request while busy, then start_row clears the error and drops a same-cycle request
    run_job(200, 1'b0, 9, 4, 8);
    @(negedge clk);
    jif.start_row = 1'b1;
    drive_fields(50, 1'b0, 3, 2);
    jif.draw_req = 1'b1;
    @(negedge clk);
    jif.start_row = 1'b0;
    jif.draw_req  = 1'b0;
    err_model     = 1'b0;
    check_eq("sr_err", 32'(jif.req_err), 32'd0);
    check_eq("sr_done", 32'(jif.draw_done), 32'd1);
    check_quiet("sr_drop", 20);

    // start_row aborts a job in flight
    start_only(300, 1'b0, 3, 2);
    repeat (5) @(negedge clk);
    jif.start_row = 1'b1;
    @(negedge clk);
    jif.start_row = 1'b0;
    check_eq("abort_done", 32'(jif.draw_done), 32'd1);
    check_eq("abort_we", 32'(lb_we), 32'd0);
    check_quiet("abort", 20);

    // Asynchronous reset in the middle of a job
    start_only(300, 1'b0, 3, 2);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_we", 32'(lb_we), 32'd0);
    check_eq("arst_done", 32'(jif.draw_done), 32'd1);
    check_eq("arst_rom", 32'(rom_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_quiet("arst", 20);

    // Randomized jobs, biased toward the right screen edge
    for (int j = 0; j < 24; j++) begin
      int col;
      col = ($urandom_range(0, 1) == 1) ? $urandom_range(620, 645) : $urandom_range(0, 1023);
      run_job(col, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 15), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
